// File: rtl/trace_arb_pkg.sv
// Shared defaults and helpers for the trace arbiter.
// Optional drop counters are enabled with TRACE_ARB_DROP_CNT_EN.
package trace_arb_pkg;

    localparam int NS_DEF    = 5;
    localparam int FPAY_DEF  = 32;
    localparam int DROPW_DEF = 8;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int SRCw = log2(NS_DEF);

endpackage

// File: rtl/trace_rr_arb.sv
// Round-robin grant: first requester at or after ptr, wrapping at NS.
module trace_rr_arb
    import trace_arb_pkg::*;
#(
    parameter int NS = NS_DEF
) (
    input  logic [NS-1:0]          req,
    input  logic [log2(NS)-1:0]    ptr,
    output logic [NS-1:0]          grant,
    output logic [log2(NS)-1:0]    idx,
    output logic                   valid
);

    localparam int SW = log2(NS);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 0; k < NS; k++) begin
            j = int'(ptr) + k;
            if (j >= NS) j = j - NS;
            if (!valid && req[j]) begin
                valid    = 1'b1;
                grant[j] = 1'b1;
                idx      = SW'(j);
            end
        end
    end

endmodule

// File: rtl/trace_arbiter.sv
// Merges NS trace sources into one trace-buffer write port.
// Per-source drop counters exist only with TRACE_ARB_DROP_CNT_EN.
module trace_arbiter
    import trace_arb_pkg::*;
#(
    parameter int NS    = NS_DEF,
    parameter int Fpay  = FPAY_DEF,
    parameter int DROPw = DROPW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NS-1:0]         trigger_in,
    input  logic [NS*Fpay-1:0]    trace_in,
    input  logic                  tb_ready,
    output logic                  trigger_out,
    output logic [Fpay-1:0]       trace_out,
    output logic [log2(NS)-1:0]   src_out,
    output logic [NS-1:0]         drop_flag,
`ifdef TRACE_ARB_DROP_CNT_EN
    output logic [NS*DROPw-1:0]   drop_cnt_all,
`endif
    input  logic                  drop_clr
);

    localparam int SW = log2(NS);

    logic [NS-1:0]   hv;
    logic [Fpay-1:0] hd [NS];
    logic [SW-1:0]   ptr;

    logic [NS-1:0]   req;
    logic [NS-1:0]   grant;
    logic [NS-1:0]   drop;
    logic [SW-1:0]   gidx;
    logic            gvalid;

    assign req  = hv & {NS{tb_ready}};
    // A trigger on a held source is lost unless that source is leaving now
    assign drop = trigger_in & hv & ~grant;

    trace_rr_arb #(
        .NS(NS)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .valid (gvalid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hv <= '0;
            for (int i = 0; i < NS; i++) hd[i] <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (trigger_in[i] && (!hv[i] || grant[i])) begin
                    hd[i] <= trace_in[i*Fpay +: Fpay];
                    hv[i] <= 1'b1;
                end else if (grant[i]) begin
                    hv[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trigger_out <= 1'b0;
            trace_out   <= '0;
            src_out     <= '0;
            ptr         <= '0;
        end else if (gvalid) begin
            trigger_out <= 1'b1;
            trace_out   <= hd[gidx];
            src_out     <= gidx;
            ptr         <= (gidx == SW'(NS - 1)) ? '0 : gidx + 1'b1;
        end else begin
            trigger_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_flag <= '0;
        end else begin
            drop_flag <= (drop_flag & ~{NS{drop_clr}}) | drop;
        end
    end

`ifdef TRACE_ARB_DROP_CNT_EN
    logic [DROPw-1:0] cnt [NS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (drop_clr) begin
                    cnt[i] <= drop[i] ? DROPw'(1) : '0;
                end else if (drop[i] && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < NS; i++) begin : g_cnt
        assign drop_cnt_all[i*DROPw +: DROPw] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_trace_arbiter.sv
// Scoreboard bench for trace_arbiter; counter checks need TRACE_ARB_DROP_CNT_EN.
module tb_trace_arbiter;

    localparam int NS    = 5;
    localparam int FP    = 32;
    localparam int DW    = 8;

    typedef struct packed {
        logic [2:0]    src;
        logic [FP-1:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NS-1:0]   trigger_in = '0;
    logic [NS*FP-1:0] trace_in = '0;
    logic            tb_ready = 1'b0;
    logic            trigger_out;
    logic [FP-1:0]   trace_out;
    logic [2:0]      src_out;
    logic [NS-1:0]   drop_flag;
    logic            drop_clr = 1'b0;
`ifdef TRACE_ARB_DROP_CNT_EN
    logic [NS*DW-1:0] drop_cnt_all;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t got_e;

    trace_arbiter #(.NS(NS), .Fpay(FP), .DROPw(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger_in  (trigger_in),
        .trace_in    (trace_in),
        .tb_ready    (tb_ready),
        .trigger_out (trigger_out),
        .trace_out   (trace_out),
        .src_out     (src_out),
        .drop_flag   (drop_flag),
`ifdef TRACE_ARB_DROP_CNT_EN
        .drop_cnt_all(drop_cnt_all),
`endif
        .drop_clr    (drop_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && trigger_out) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got src=%0d data=%h, required none",
                         src_out, trace_out);
            end else begin
                got_e = q.pop_front();
                if (src_out !== got_e.src || trace_out !== got_e.data) begin
                    errors++;
                    $display("FAIL scoreboard: got src=%0d data=%h, required src=%0d data=%h",
                             src_out, trace_out, got_e.src, got_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [FP-1:0] v);
        trace_in[i*FP +: FP] = v;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        for (int n = 0; n < max && q.size() != 0; n++) step();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (trigger_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_trigger_out: got %b, required 0", trigger_out);
        end
        checks++;
        if (trace_out !== '0) begin
            errors++;
            $display("FAIL reset_trace_out: got %h, required 0", trace_out);
        end
        checks++;
        if (src_out !== '0) begin
            errors++;
            $display("FAIL reset_src_out: got %0d, required 0", src_out);
        end
        checks++;
        if (drop_flag !== '0) begin
            errors++;
            $display("FAIL reset_drop_flag: got %b, required 0", drop_flag);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        tb_ready = 1'b1;
        set_word(0, 32'hA5A5A5A5);
        trigger_in = 5'b00001;
        q.push_back('{src: 3'd0, data: 32'hA5A5A5A5});
        step();
        trigger_in = '0;
        checks++;
        if (trigger_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got %b, required 0", trigger_out);
        end
        step();
        checks++;
        if (trigger_out !== 1'b1 || src_out !== 3'd0 || trace_out !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL latency_single: got t=%b s=%0d d=%h, required t=1 s=0 d=a5a5a5a5",
                     trigger_out, src_out, trace_out);
        end
        wait_drain(10);
    endtask

    task automatic test_all_sources();
        do_reset();
        tb_ready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            set_word(i, FP'(i));
            q.push_back('{src: 3'(i), data: FP'(i)});
        end
        trigger_in = '1;
        step();
        trigger_in = '0;
        for (int k = 0; k < NS; k++) begin
            step();
            checks++;
            if (trigger_out !== 1'b1 || src_out !== 3'(k)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got t=%b s=%0d, required t=1 s=%0d",
                         k, trigger_out, src_out, k);
            end
        end
        wait_drain(10);
        checks++;
        if (drop_flag !== '0) begin
            errors++;
            $display("FAIL rr_no_drop: got %b, required 0", drop_flag);
        end
    endtask

    task automatic test_drop();
        tb_ready = 1'b0;
        set_word(2, 32'h11);
        trigger_in = 5'b00100;
        step();
        set_word(2, 32'h22);
        step();
        trigger_in = '0;
        checks++;
        if (drop_flag[2] !== 1'b1) begin
            errors++;
            $display("FAIL drop_flag2: got %b, required 1", drop_flag[2]);
        end
`ifdef TRACE_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt_all[2*DW +: DW] !== 8'd1) begin
            errors++;
            $display("FAIL drop_cnt2: got %0d, required 1", drop_cnt_all[2*DW +: DW]);
        end
`endif
        q.push_back('{src: 3'd2, data: 32'h11});
        tb_ready = 1'b1;
        wait_drain(10);
        repeat (3) step();
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        checks++;
        if (drop_flag !== '0) begin
            errors++;
            $display("FAIL drop_clr: got %b, required 0", drop_flag);
        end
        tb_ready = 1'b0;
        set_word(2, 32'h55);
        trigger_in = 5'b00100;
        step();
        set_word(2, 32'h66);
        drop_clr = 1'b1;
        step();
        trigger_in = '0;
        drop_clr = 1'b0;
        checks++;
        if (drop_flag[2] !== 1'b1) begin
            errors++;
            $display("FAIL drop_wins_clr: got %b, required 1", drop_flag[2]);
        end
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        q.push_back('{src: 3'd2, data: 32'h55});
        tb_ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_saturate();
        tb_ready = 1'b0;
        trigger_in = 5'b00010;
        for (int k = 0; k < 300; k++) begin
            set_word(1, 32'h1000 + FP'(k));
            step();
        end
        trigger_in = '0;
        checks++;
        if (drop_flag[1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag: got %b, required 1", drop_flag[1]);
        end
`ifdef TRACE_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt_all[1*DW +: DW] !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt: got %0d, required 255", drop_cnt_all[1*DW +: DW]);
        end
`endif
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        checks++;
        if (drop_flag[1] !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr_flag: got %b, required 0", drop_flag[1]);
        end
`ifdef TRACE_ARB_DROP_CNT_EN
        checks++;
        if (drop_cnt_all[1*DW +: DW] !== 8'd0) begin
            errors++;
            $display("FAIL sat_clr_cnt: got %0d, required 0", drop_cnt_all[1*DW +: DW]);
        end
`endif
        q.push_back('{src: 3'd1, data: 32'h1000});
        tb_ready = 1'b1;
        wait_drain(10);
    endtask

    task automatic test_reset_mid();
        int seen;
        tb_ready = 1'b0;
        set_word(0, 32'hAA);
        set_word(2, 32'hBB);
        set_word(4, 32'hCC);
        trigger_in = 5'b10101;
        step();
        trigger_in = '0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (trigger_out !== 1'b0 || trace_out !== '0 || src_out !== '0 || drop_flag !== '0) begin
            errors++;
            $display("FAIL reset_async: got t=%b d=%h s=%0d f=%b, required all 0",
                     trigger_out, trace_out, src_out, drop_flag);
        end
        step();
        reset = 1'b0;
        tb_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (trigger_out === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_output: got %0d pulses, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        tb_ready = 1'b1;
        set_word(3, 32'h33);
        trigger_in = 5'b01000;
        q.push_back('{src: 3'd3, data: 32'h33});
        step();
        set_word(3, 32'h44);
        q.push_back('{src: 3'd3, data: 32'h44});
        step();
        trigger_in = '0;
        checks++;
        if (trigger_out !== 1'b1 || trace_out !== 32'h33) begin
            errors++;
            $display("FAIL b2b_first: got t=%b d=%h, required t=1 d=33", trigger_out, trace_out);
        end
        step();
        checks++;
        if (trigger_out !== 1'b1 || trace_out !== 32'h44) begin
            errors++;
            $display("FAIL b2b_second: got t=%b d=%h, required t=1 d=44", trigger_out, trace_out);
        end
        wait_drain(10);
        checks++;
        if (drop_flag[3] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_drop: got %b, required 0", drop_flag[3]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_sources();
        test_drop();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_arbiter.md
TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 Parameter NS, default 5: number of trace sources (4 tiles plus the NoC).
REQ-002 Parameter Fpay, default 32: trace word width.
REQ-003 Parameter DROPw, default 8: width of each drop counter.
REQ-004 Port clk, input, 1: single clock; reset is asynchronous and active-high.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port trigger_in, input, NS: per-source capture strobe; bit i belongs to source i.
REQ-007 Port trace_in, input, NS*Fpay: per-source trace word; source i occupies [(i+1)*Fpay-1 : i*Fpay].
REQ-008 Port tb_ready, input, 1: trace buffer can accept a word this cycle.
REQ-009 Port trigger_out, input-to-buffer strobe, output, 1: write enable to the trace buffer.
REQ-010 Port trace_out, output, Fpay: word written to the trace buffer.
REQ-011 Port src_out, output, log2(NS): index of the source of trace_out.
REQ-012 Port drop_flag, output, NS: sticky per-source loss indicator.
REQ-013 Port drop_clr, input, 1: clears drop_flag and the drop counters.
REQ-014 Port drop_cnt_all, output, NS*DROPw: per-source drop counts; present only when TRACE_ARB_DROP_CNT_EN is defined.

Function
REQ-015 Each source SHALL have a one-entry hold register (hv[i], hd[i]); on trigger_in[i]=1 with hv[i]=0, hd[i] SHALL load trace_in slice i and hv[i] SHALL set.
REQ-016 Arbiter SHALL grant exactly one source among those with hv=1 per cycle when tb_ready=1; no grant when tb_ready=0 or no hv set.
REQ-017 Grant SHALL be round-robin: search starts at ptr; after a grant to source g, ptr SHALL become (g+1) mod NS; ptr is unchanged when there is no grant.
REQ-018 On grant g, the next clock edge SHALL register trigger_out=1, trace_out=hd[g], src_out=g, and clear hv[g]; otherwise trigger_out=0, and trace_out/src_out hold their values.
REQ-019 Latency: trigger_in sampled at edge t with the source idle and uncontested SHALL produce trigger_out=1 after edge t+1 (two edges).
REQ-020 A trigger_in[i] in the same cycle as a grant to i SHALL reload hd[i] and keep hv[i]=1 (no loss).
REQ-021 A trigger_in[i] with hv[i]=1 and no grant to i SHALL discard the new word, keep hd[i], and set drop_flag[i].
REQ-022 drop_clr SHALL clear all drop_flag bits at the next edge; a drop in the same cycle SHALL win, leaving the flag set.
REQ-023 Simultaneous triggers on all NS sources SHALL all be captured and emitted over NS grant cycles in round-robin order.

Reset
REQ-024 Reset SHALL asynchronously clear hv, hd, ptr, trigger_out, trace_out, src_out, drop_flag, and the drop counters to 0.
REQ-025 Reset asserted mid-operation SHALL discard all held words, and no trigger_out SHALL follow the deassertion of reset.

Configuration
REQ-026 With TRACE_ARB_DROP_CNT_EN defined, each source SHALL have a DROPw-bit counter that increments on every drop (REQ-021), saturates at all-ones, and clears on drop_clr; drop_cnt_all SHALL be exposed.
REQ-027 Without TRACE_ARB_DROP_CNT_EN, the counters and the drop_cnt_all port SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package trace_arb_pkg SHALL hold the NS, Fpay, and DROPw defaults, the SRCw=log2(NS) constant, and the log2 function.
REQ-029 The round-robin grant logic SHALL be a sub-module trace_rr_arb (request vector and ptr in, one-hot grant and index out); holds, counters, and output registers stay in trace_arbiter.

Verification
REQ-030 Pulse trigger_in=5'b00001 with trace 0xA5A5A5A5 and tb_ready=1 -> trigger_out=1 two edges later, trace_out=0xA5A5A5A5, src_out=0.
REQ-031 Pulse trigger_in=5'b11111 with trace_in[i]=i and ptr=0 -> five consecutive trigger_out pulses with src_out 0,1,2,3,4; drop_flag stays 0.
REQ-032 Hold tb_ready=0, then pulse trigger_in[2] twice (0x11, then 0x22) -> drop_flag[2]=1 and drop_cnt[2]=1; after tb_ready=1, one word 0x11 is emitted.
REQ-033 Hold tb_ready=0 and trigger source 1 for 300 cycles -> drop_cnt[1] saturates at 255; pulse drop_clr -> drop_cnt[1]=0 and drop_flag[1]=0.
REQ-034 Assert reset while three sources are held -> all outputs become 0 immediately; after deassertion there is no trigger_out until a new trigger_in.
REQ-035 Trigger source 3 again in the same cycle it is granted -> both words are emitted back-to-back when source 3 is the only requester, with no drop.
